// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, frame marker
// and status-bit positions used to pack busy/done/error.
package prog_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHECK   = 2'd3
  } loader_state_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  localparam int STATUS_W         = 3;
  localparam int STATUS_BUSY_BIT  = 0;
  localparam int STATUS_DONE_BIT  = 1;
  localparam int STATUS_ERROR_BIT = 2;

  // Running checksum is plain 8-bit wrap-around addition.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/prog_loader_strobe_sync.sv
// Brings the asynchronous host strobe into the clock domain and emits a
// single-cycle accept pulse on each rising edge (third clock edge after the rise).
module prog_loader_strobe_sync (
  input  logic clock,
  input  logic rst_n,
  input  logic host_strobe,
  output logic accept_pulse
);

  logic sync1_q;
  logic sync2_q;
  logic sync2_prev_q;
  logic accept_q;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync2_prev_q <= 1'b0;
      accept_q     <= 1'b0;
    end else begin
      sync1_q      <= host_strobe;
      sync2_q      <= sync1_q;
      sync2_prev_q <= sync2_q;
      accept_q     <= sync2_q & ~sync2_prev_q;
    end
  end

  assign accept_pulse = accept_q;

endmodule

// File: rtl/prog_loader.sv
// Frames a host byte stream (sync, length, payload, checksum) into one-cycle
// instruction-memory writes, with inter-byte timeout and sticky status flags.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [7:0]               SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int                       TIMEOUT_WIDTH  = 16,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       host_strobe,
  input  logic [7:0] host_data,
  output logic       prog_enable,
  output logic [7:0] prog_data,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [TIMEOUT_WIDTH-1:0] TIMER_ONE  = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_WIDTH-1:0] TIMER_LAST = TIMEOUT_CYCLES - TIMER_ONE;

  logic accept;

  loader_state_e            state_q,       state_d;
  logic [7:0]               count_q,       count_d;
  logic [7:0]               sum_q,         sum_d;
  logic [TIMEOUT_WIDTH-1:0] timer_q,       timer_d;
  logic [STATUS_W-1:0]      status_q,      status_d;
  logic                     prog_enable_q, prog_enable_d;
  logic [7:0]               prog_data_q,   prog_data_d;

  prog_loader_strobe_sync u_strobe_sync (
    .clock        (clock),
    .rst_n        (rst_n),
    .host_strobe  (host_strobe),
    .accept_pulse (accept)
  );

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      count_q       <= 8'd0;
      sum_q         <= 8'd0;
      timer_q       <= '0;
      status_q      <= '0;
      prog_enable_q <= 1'b0;
      prog_data_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      sum_q         <= sum_d;
      timer_q       <= timer_d;
      status_q      <= status_d;
      prog_enable_q <= prog_enable_d;
      prog_data_q   <= prog_data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    sum_d         = sum_q;
    timer_d       = timer_q;
    status_d      = status_q;
    prog_enable_d = 1'b0;
    prog_data_d   = prog_data_q;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (accept && host_data == SYNC_BYTE) begin
          state_d                    = ST_LEN;
          sum_d                      = 8'd0;
          status_d                   = '0;
          status_d[STATUS_BUSY_BIT]  = 1'b1;
        end
      end
      ST_LEN: begin
        if (accept) begin
          count_d = host_data;
          state_d = (host_data == 8'd0) ? ST_CHECK : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          prog_data_d   = host_data;
          prog_enable_d = 1'b1;
          sum_d         = csum_add(sum_q, host_data);
          count_d       = count_q - 8'd1;
          if (count_q == 8'd1) begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (accept) begin
          if (host_data == sum_q) begin
            status_d[STATUS_DONE_BIT] = 1'b1;
          end else begin
            status_d[STATUS_ERROR_BIT] = 1'b1;
          end
          status_d[STATUS_BUSY_BIT] = 1'b0;
          state_d                   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Mid-frame watchdog: abort on the edge that would bring the timer to
    // TIMEOUT_CYCLES; an accept in the same cycle takes priority.
    if (state_q != ST_IDLE) begin
      if (accept) begin
        timer_d = '0;
      end else if (timer_q >= TIMER_LAST) begin
        timer_d                    = '0;
        state_d                    = ST_IDLE;
        status_d[STATUS_BUSY_BIT]  = 1'b0;
        status_d[STATUS_ERROR_BIT] = 1'b1;
      end else begin
        timer_d = timer_q + TIMER_ONE;
      end
    end
  end

  assign prog_enable = prog_enable_q;
  assign prog_data   = prog_data_q;
  assign busy        = status_q[STATUS_BUSY_BIT];
  assign done        = status_q[STATUS_DONE_BIT];
  assign error       = status_q[STATUS_ERROR_BIT];

endmodule

// File: tb/tb_prog_loader.sv
// Directed plus randomized frame-level checks of prog_loader against a
// behavioural model: expected writes are the payload, done iff checksum matches.
module tb_prog_loader;

  localparam int TMO = 50;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       host_strobe;
  logic [7:0] host_data;
  logic       prog_enable;
  logic [7:0] prog_data;
  logic       busy;
  logic       done;
  logic       error;

  int checks = 0;
  int errors = 0;

  logic [7:0] pulses[$];
  logic [7:0] payload_q[$];
  logic [7:0] last_data;

  always #5 clock = ~clock;

  prog_loader #(
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_WIDTH  (16),
    .TIMEOUT_CYCLES (16'd50)
  ) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .host_strobe (host_strobe),
    .host_data   (host_data),
    .prog_enable (prog_enable),
    .prog_data   (prog_data),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always @(negedge clock) begin
    if (prog_enable === 1'b1) pulses.push_back(prog_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raise the strobe with a byte and return just after the edge that consumes it.
  task automatic strobe_byte(input logic [7:0] b, input int high_cycles);
    host_data   = b;
    host_strobe = 1'b1;
    repeat (high_cycles) @(posedge clock);
    #1;
    host_strobe = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    strobe_byte(b, 4);
    repeat (4) @(posedge clock);
    #1;
  endtask

  // Sends a whole frame from payload_q; checksum is the true sum unless overridden.
  task automatic run_frame(input string tag, input bit corrupt, input logic [7:0] bad_ck);
    logic [7:0] sum;
    logic [7:0] ck;
    sum = 8'd0;
    foreach (payload_q[i]) sum = sum + payload_q[i];
    ck = corrupt ? bad_ck : sum;
    pulses.delete();
    send_byte(8'hA5);
    check({tag, ".busy_start"}, busy, 1);
    send_byte(8'(payload_q.size()));
    foreach (payload_q[i]) send_byte(payload_q[i]);
    send_byte(ck);
    check({tag, ".npulses"}, pulses.size(), payload_q.size());
    for (int i = 0; i < payload_q.size() && i < pulses.size(); i++)
      check({tag, ".pulse"}, pulses[i], payload_q[i]);
    if (payload_q.size() > 0) last_data = payload_q[payload_q.size()-1];
    check({tag, ".prog_data_hold"}, prog_data, last_data);
    check({tag, ".done"}, done, (ck == sum));
    check({tag, ".error"}, error, (ck != sum));
    check({tag, ".busy_end"}, busy, 0);
    $display("frame %s len=%0d ck=%02h sum=%02h pulses=%0d done=%0b error=%0b",
             tag, payload_q.size(), ck, sum, pulses.size(), done, error);
  endtask

  initial begin
    rst_n       = 1'b0;
    host_strobe = 1'b0;
    host_data   = 8'h00;
    last_data   = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    check("reset.prog_enable", prog_enable, 0);
    check("reset.prog_data", prog_data, 0);
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.error", error, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    payload_q = '{8'h11, 8'h22, 8'h33};
    run_frame("good", 1'b0, 8'h00);

    // Idle noise must not disturb the sticky flags.
    pulses.delete();
    send_byte(8'h42);
    check("noise.npulses", pulses.size(), 0);
    check("noise.done", done, 1);
    check("noise.busy", busy, 0);
    send_byte(8'hA5);
    check("resync.done_cleared", done, 0);
    check("resync.busy", busy, 1);
    send_byte(8'h00);
    send_byte(8'h00);
    check("resync.done", done, 1);

    payload_q = '{8'h10, 8'h20};
    run_frame("badck", 1'b1, 8'h31);

    payload_q = {};
    run_frame("empty", 1'b0, 8'h00);

    payload_q = '{8'hA5};
    run_frame("sync_in_payload", 1'b0, 8'h00);

    // Timeout: error rises on the 50th edge after the last consumed byte.
    send_byte(8'hA5);
    send_byte(8'h04);
    strobe_byte(8'h01, 4);
    repeat (TMO - 1) @(posedge clock);
    #1;
    check("timeout.before_error", error, 0);
    check("timeout.before_busy", busy, 1);
    @(posedge clock);
    #1;
    check("timeout.error", error, 1);
    check("timeout.busy", busy, 0);
    $display("frame timeout aborted error=%0b busy=%0b", error, busy);
    payload_q = '{8'h3C};
    run_frame("after_timeout", 1'b0, 8'h00);

    // Reset mid-payload: everything back to zero, loader idle.
    send_byte(8'hA5);
    send_byte(8'h05);
    send_byte(8'h77);
    rst_n = 1'b0;
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    check("midreset.prog_enable", prog_enable, 0);
    check("midreset.prog_data", prog_data, 0);
    check("midreset.busy", busy, 0);
    check("midreset.done", done, 0);
    check("midreset.error", error, 0);
    last_data = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    pulses.delete();
    send_byte(8'h55);
    check("midreset.idle_npulses", pulses.size(), 0);
    check("midreset.idle_busy", busy, 0);
    $display("frame midreset busy=%0b done=%0b error=%0b", busy, done, error);

    // Long strobe: held high 20 cycles must count as a single sync byte.
    pulses.delete();
    strobe_byte(8'hA5, 20);
    repeat (4) @(posedge clock);
    #1;
    check("longstrobe.busy", busy, 1);
    send_byte(8'h01);
    send_byte(8'h7C);
    send_byte(8'h7C);
    check("longstrobe.npulses", pulses.size(), 1);
    check("longstrobe.done", done, 1);
    last_data = 8'h7C;
    $display("frame longstrobe pulses=%0d done=%0b", pulses.size(), done);

    // Randomized frames with idle noise, random lengths and checksums.
    for (int f = 0; f < 20; f++) begin
      int noise;
      int len;
      bit corrupt;
      logic [7:0] s;
      logic [7:0] bad;
      noise = int'($urandom_range(0, 2));
      for (int k = 0; k < noise; k++) begin
        logic [7:0] nb;
        nb = 8'($urandom_range(0, 255));
        if (nb == 8'hA5) nb = 8'h5A;
        pulses.delete();
        send_byte(nb);
        check("rand.noise_npulses", pulses.size(), 0);
      end
      len = int'($urandom_range(0, 6));
      payload_q = {};
      s = 8'd0;
      for (int k = 0; k < len; k++) begin
        payload_q.push_back(8'($urandom_range(0, 255)));
        s = s + payload_q[k];
      end
      corrupt = 1'($urandom_range(0, 1));
      bad = s ^ 8'($urandom_range(1, 255));
      run_frame("rand", corrupt, bad);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
